// File: rtl/aes_round_ctrl_if.sv
// Handshake, abort and datapath-strobe bundle between the AES round sequencer and its
// surroundings. The master side is the sequencer; the slave side is the block user.
interface aes_round_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             abort;
    logic             dp_load;
    logic             dp_round_en;
    logic             dp_skip_mix;
    logic [CNT_W-1:0] round_num;
    logic             busy;

    modport master (
        input  in_valid, out_ready, abort,
        output in_ready, out_valid, dp_load, dp_round_en, dp_skip_mix, round_num, busy
    );

    modport slave (
        output in_valid, out_ready, abort,
        input  in_ready, out_valid, dp_load, dp_round_en, dp_skip_mix, round_num, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer. Accepts one block, pulses dp_load, then issues one
// dp_round_en every STAGE_LAT cycles for NUM_ROUNDS rounds and holds out_valid until taken.
// All datapath strobes are registered decodes of the next state.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned STAGE_LAT  = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

    localparam logic [CNT_W-1:0] LAT_MAX   = CNT_W'(STAGE_LAT - 1);
    localparam logic [CNT_W-1:0] RND_MAX   = CNT_W'(NUM_ROUNDS);
    localparam logic             LAT_ONE   = (STAGE_LAT == 1);
    localparam logic             ONE_ROUND = (NUM_ROUNDS == 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_round;
    logic [CNT_W-1:0] r_lat;
    logic             r_out_valid;
    logic             r_dp_load;
    logic             r_dp_round_en;
    logic             r_dp_skip_mix;
    logic             r_busy;

    logic [CNT_W-1:0] w_lat_inc;
    logic [CNT_W-1:0] w_round_inc;
    logic             w_last_lat;
    logic             w_more_rounds;

    assign w_lat_inc     = r_lat + CNT_W'(1);
    assign w_round_inc   = r_round + CNT_W'(1);
    assign w_last_lat    = (r_lat == LAT_MAX);
    assign w_more_rounds = (r_round < RND_MAX);

    // Sequencer FSM; strobes are computed for the state being entered so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_round       <= '0;
            r_lat         <= '0;
            r_out_valid   <= 1'b0;
            r_dp_load     <= 1'b0;
            r_dp_round_en <= 1'b0;
            r_dp_skip_mix <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dp_load     <= 1'b0;
            r_dp_round_en <= 1'b0;
            if (bus.abort && (r_state != StIdle)) begin
                // Cancel drops the block wherever it is; no capture strobe follows.
                r_state       <= StIdle;
                r_round       <= '0;
                r_lat         <= '0;
                r_out_valid   <= 1'b0;
                r_dp_skip_mix <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.in_valid) begin
                            r_state   <= StLoad;
                            r_dp_load <= 1'b1;
                            r_busy    <= 1'b1;
                            r_round   <= '0;
                            r_lat     <= '0;
                        end
                    end
                    StLoad: begin
                        r_state       <= StRound;
                        r_round       <= CNT_W'(1);
                        r_lat         <= '0;
                        r_dp_round_en <= LAT_ONE;
                        r_dp_skip_mix <= ONE_ROUND;
                    end
                    StRound: begin
                        if (w_last_lat) begin
                            r_lat <= '0;
                            if (w_more_rounds) begin
                                r_round       <= w_round_inc;
                                r_dp_round_en <= LAT_ONE;
                                r_dp_skip_mix <= (w_round_inc == RND_MAX);
                            end else begin
                                r_state       <= StDone;
                                r_out_valid   <= 1'b1;
                                r_dp_skip_mix <= 1'b0;
                            end
                        end else begin
                            r_lat         <= w_lat_inc;
                            r_dp_round_en <= (w_lat_inc == LAT_MAX);
                        end
                    end
                    StDone: begin
                        if (bus.out_ready) begin
                            r_state     <= StIdle;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_round     <= '0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.in_ready    = (r_state == StIdle);
    assign bus.out_valid   = r_out_valid;
    assign bus.dp_load     = r_dp_load;
    assign bus.dp_round_en = r_dp_round_en;
    assign bus.dp_skip_mix = r_dp_skip_mix;
    assign bus.round_num   = r_round;
    assign bus.busy        = r_busy;

endmodule
